// File: rtl/iir_seq_pkg.sv
// Shared types and default sizes for the IIR run-level sequencer.
package iir_seq_pkg;

    localparam int unsigned DW_DEF        = 12;
    localparam int unsigned CW_DEF        = 12;
    localparam int unsigned NCOEF_DEF     = 5;
    localparam int unsigned CNTW_DEF      = 16;
    localparam int unsigned FLUSH_LEN_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        RUN,
        FLUSH,
        DRAIN,
        DONE_S
    } state_t;

endpackage

// File: rtl/iir_seq_ctrl_rate_timer.sv
// Down-counting issue-rate timer; tick is asserted whenever the count sits at zero.
module iir_rate_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  logic       advance,
    input  logic [7:0] rate_div,
    output logic       tick
);

    logic [7:0] cnt;

    assign tick = (cnt == 8'd0);

    // A divider of 0 behaves as 1, so both reload to zero and tick every cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= (rate_div == 8'd0) ? 8'd0 : rate_div - 8'd1;
        end else if (advance && !tick) begin
            cnt <= cnt - 8'd1;
        end
    end

endmodule

// File: rtl/iir_seq_ctrl.sv
// Run sequencer for the IIR filter: clear, coefficient load, paced sample feed, flush, drain.
module iir_seq_ctrl
    import iir_seq_pkg::*;
#(
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned CW        = CW_DEF,
    parameter int unsigned NCOEF     = NCOEF_DEF,
    parameter int unsigned CNTW      = CNTW_DEF,
    parameter int unsigned FLUSH_LEN = FLUSH_LEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CNTW-1:0] n_samples,
    input  logic [7:0]      rate_div,
    input  logic            coef_wr,
    input  logic [2:0]      coef_waddr,
    input  logic [CW-1:0]   coef_wdata,
    input  logic            src_valid,
    input  logic [DW-1:0]   src_data,
    output logic            src_ready,
    output logic            filt_clr,
    output logic            filt_coef_we,
    output logic [2:0]      filt_coef_addr,
    output logic [CW-1:0]   filt_coef_data,
    output logic            filt_vin,
    output logic [DW-1:0]   filt_din,
    input  logic            filt_vout,
    input  logic [DW-1:0]   filt_dout,
    output logic            snk_valid,
    output logic [DW-1:0]   snk_data,
    output logic [CNTW-1:0] out_cnt,
    output logic            busy,
    output logic            done,
    output logic            err_underrun
);

    state_t          state;
    logic [CW-1:0]   shadow [NCOEF];
    logic [CNTW-1:0] n_q;
    logic [7:0]      rate_q;
    logic [CNTW-1:0] issued;
    logic [2:0]      load_idx;
    logic            clr_q;

    logic            tick;
    logic            run_issue;
    logic            flush_issue;
    logic            issue;
    logic            take_out;
    logic [CNTW-1:0] issued_nx;
    logic [CNTW-1:0] out_cnt_nx;
    logic [CNTW-1:0] drain_target;
    logic [2:0]      load_idx_nx;

    always_comb begin
        run_issue    = (state == RUN) && tick && src_valid;
        flush_issue  = (state == FLUSH) && tick;
        issue        = run_issue || flush_issue;
        take_out     = filt_vout && (state != IDLE);
        issued_nx    = issued + 1'b1;
        load_idx_nx  = load_idx + 3'd1;
        drain_target = n_q + CNTW'(FLUSH_LEN);
        out_cnt_nx   = out_cnt;
        if (take_out) begin
            out_cnt_nx = out_cnt + 1'b1;
        end
    end

    // Reset drives the clear combinationally so the filter is held clear for the whole reset.
    assign filt_clr  = clr_q | rst;
    assign src_ready = run_issue && !rst;

    iir_rate_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == LOAD),
        .load     (issue),
        .advance  ((state == RUN) || (state == FLUSH)),
        .rate_div (rate_q),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            n_q            <= '0;
            rate_q         <= '0;
            issued         <= '0;
            load_idx       <= '0;
            clr_q          <= 1'b0;
            filt_coef_we   <= 1'b0;
            filt_coef_addr <= '0;
            filt_coef_data <= '0;
            filt_vin       <= 1'b0;
            filt_din       <= '0;
            snk_valid      <= 1'b0;
            snk_data       <= '0;
            out_cnt        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_underrun   <= 1'b0;
            for (int i = 0; i < int'(NCOEF); i++) begin
                shadow[i] <= '0;
            end
        end else begin
            clr_q     <= 1'b0;
            done      <= 1'b0;
            filt_vin  <= issue;
            snk_valid <= take_out;
            out_cnt   <= out_cnt_nx;
            if (issue) begin
                filt_din <= run_issue ? src_data : '0;
            end
            if (take_out) begin
                snk_data <= filt_dout;
            end
            if ((state == RUN) && tick && !src_valid) begin
                err_underrun <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state        <= CLEAR;
                        n_q          <= n_samples;
                        rate_q       <= rate_div;
                        out_cnt      <= '0;
                        err_underrun <= 1'b0;
                        clr_q        <= 1'b1;
                        busy         <= 1'b1;
                    end else if (coef_wr && ({29'd0, coef_waddr} < NCOEF)) begin
                        shadow[coef_waddr] <= coef_wdata;
                    end
                end
                CLEAR: begin
                    state          <= LOAD;
                    load_idx       <= 3'd0;
                    filt_coef_we   <= 1'b1;
                    filt_coef_addr <= 3'd0;
                    filt_coef_data <= shadow[0];
                end
                LOAD: begin
                    if (load_idx == 3'(NCOEF - 1)) begin
                        filt_coef_we   <= 1'b0;
                        filt_coef_addr <= 3'd0;
                        filt_coef_data <= '0;
                        issued         <= '0;
                        state          <= (n_q != '0) ? RUN : FLUSH;
                    end else begin
                        load_idx       <= load_idx_nx;
                        filt_coef_addr <= load_idx_nx;
                        filt_coef_data <= shadow[load_idx_nx];
                    end
                end
                RUN: begin
                    if (run_issue) begin
                        issued <= issued_nx;
                        if (issued_nx == n_q) begin
                            issued <= '0;
                            state  <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_issue) begin
                        issued <= issued_nx;
                        if (issued_nx == CNTW'(FLUSH_LEN)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // An output arriving this cycle is already included in out_cnt_nx.
                    if (out_cnt_nx == drain_target) begin
                        state <= DONE_S;
                        done  <= 1'b1;
                    end
                end
                DONE_S: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/iir_seq_ctrl.md
Name: iir_seq_ctrl

Overview:
Run-level sequencer for the IIR filter datapath (12-bit DIN/VIN in, DOUT/VOUT out).
- On START, clears the filter state, then loads coefficients from a host-written shadow bank.
- Streams a programmed number of samples from a valid/ready source at a programmable rate.
- Feeds zeros to flush the recursion, counts filter outputs, and pulses DONE.
- Sits between the sample source/host and the filter; it replaces the free-running stimulus driver in system use.

Parameters:
DW, 12, sample width (filter DIN/DOUT)
CW, 12, coefficient width
NCOEF, 5, coefficients per filter (address 0..NCOEF-1)
CNTW, 16, sample/output counter width
FLUSH_LEN, 8, zero samples issued after the last real sample

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  synchronous, active-high reset
START  in  1  single-cycle run request
N_SAMPLES  in  CNTW  real samples per run; latched at START
RATE_DIV  in  8  cycles between filter issues; latched at START; 0 treated as 1
COEF_WR  in  1  host write strobe to shadow bank
COEF_WADDR  in  3  shadow bank address
COEF_WDATA  in  CW  shadow bank data
SRC_VALID  in  1  source sample valid
SRC_DATA  in  DW  source sample
SRC_READY  out  1  source sample accepted this cycle
FILT_CLR  out  1  filter state clear, active-high; integrator adapts polarity
FILT_COEF_WE  out  1  coefficient write to filter
FILT_COEF_ADDR  out  3  coefficient address
FILT_COEF_DATA  out  CW  coefficient value
FILT_VIN  out  1  sample valid to filter
FILT_DIN  out  DW  sample to filter
FILT_VOUT  in  1  filter output valid
FILT_DOUT  in  DW  filter output
SNK_VALID  out  1  forwarded output valid
SNK_DATA  out  DW  forwarded output
OUT_CNT  out  CNTW  filter outputs received this run
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse at run end
ERR_UNDERRUN  out  1  sticky flag; source not valid at an issue tick

Behaviour:
- Reset: state IDLE; shadow bank all 0. All outputs are 0 except FILT_CLR, which is 1 while RST=1.
- RST mid-run: run is aborted with no DONE; state and counters return to reset values on the next edge.
- COEF_WR is honoured only in IDLE (shadow[COEF_WADDR] <= COEF_WDATA); ignored when BUSY. Addresses >= NCOEF are ignored.
- START is honoured only in IDLE; ignored when BUSY.
- FSM states and transitions:
  - IDLE -> CLEAR on START. Latch N_SAMPLES and RATE_DIV; clear OUT_CNT and ERR_UNDERRUN.
  - CLEAR: FILT_CLR=1 for exactly 1 cycle -> LOAD.
  - LOAD: NCOEF cycles with FILT_COEF_WE=1, address 0,1,...,NCOEF-1 and data = shadow[addr]. After the last write: -> RUN if N_SAMPLES!=0, else -> FLUSH.
  - RUN: rate timer reloads RATE_DIV-1 on each issue and decrements otherwise. tick = (timer==0); the first RUN cycle is a tick.
    - On tick with SRC_VALID=1: SRC_READY=1 (combinational), FILT_VIN=1, FILT_DIN=SRC_DATA, issued count +1.
    - On tick with SRC_VALID=0: no issue; ERR_UNDERRUN <= 1; timer holds at 0 until valid.
    - SRC_READY is 0 on all non-tick cycles and outside RUN.
    - After issue number N_SAMPLES -> FLUSH.
  - FLUSH: FLUSH_LEN issues of FILT_DIN=0 at the same rate, independent of the source -> DRAIN.
  - DRAIN: wait until OUT_CNT == N_SAMPLES+FLUSH_LEN -> DONE.
  - DONE: DONE=1 for 1 cycle -> IDLE.
- FILT_VIN/FILT_DIN are registered: the filter sees them one cycle after the issue decision. SRC_READY is in the same cycle as the source handshake.
- Output path:
  - From CLEAR onward, every FILT_VOUT=1 increments OUT_CNT (wraps at 2^CNTW).
  - SNK_VALID/SNK_DATA = FILT_VOUT/FILT_DOUT delayed by 1 register; latency 1.
  - Outputs in IDLE are dropped and not counted.
- FILT_VOUT in the same cycle as the DRAIN exit comparison is counted before the compare (use the next-count value).

Decomposition:
- Package iir_seq_pkg: state enum (IDLE, CLEAR, LOAD, RUN, FLUSH, DRAIN, DONE_S), DW/CW/CNTW defaults, NCOEF, FLUSH_LEN default.
- One natural sub-module: iir_rate_timer. Inputs: load, RATE_DIV, advance. Output: tick. Holds at 0 while not advanced.

Test Plan:
- Shadow writes 0x100,0x200,0x100,0xE00,0x080 then START -> CLEAR for 1 cycle, then 5 FILT_COEF_WE cycles with addr 0..4 and matching data; BUSY from cycle after START.
- N_SAMPLES=4, RATE_DIV=3, source always valid -> FILT_VIN every 3rd cycle; 4 samples then 8 zeros; DONE once OUT_CNT=12 (model filter latency 2); ERR_UNDERRUN=0.
- RATE_DIV=0, N_SAMPLES=3 -> issues on consecutive cycles, same as RATE_DIV=1.
- SRC_VALID dropped for 5 cycles at a tick -> no FILT_VIN during the gap; ERR_UNDERRUN=1 and sticky until next START; all 3 samples still issued in order.
- N_SAMPLES=0 -> LOAD goes straight to FLUSH; 8 zero issues; DONE after OUT_CNT=8.
- RST pulsed in RUN, then COEF_WR and START during BUSY in a later run -> on RST: FILT_CLR=1, all outputs 0, no DONE; during BUSY: shadow unchanged, run not restarted.
